calc_datapath_mc: RTL and testbench

//  Parametrised multi-cycle ALU datapath for the 16-bit multi-cycle core.
//  - Latches A/B operands; selects sources via ALUSrcA/ALUSrcB muxes; executes; registers ALUOut and flags.
//  - Adds a start/busy/done handshake and optional iterative multiply.
//  - Drives the PCSrc-selected next-PC value.

---
 rtl/calc_datapath_mc_if.sv | 36 +++
 rtl/calc_datapath_mc.sv | 215 +++++++++++++++++++++
 tb/tb_calc_datapath_mc.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/calc_datapath_mc_if.sv
// rtl/calc_datapath_mc_if.sv - operand, control and result bundle for calc_datapath_mc
// master drives operands/controls, slave (the datapath) drives results and handshake.
interface calc_datapath_mc_if #(
  parameter int WIDTH = 16
) ();
  logic             input_start;
  logic [WIDTH-1:0] input_A;
  logic [WIDTH-1:0] input_B;
  logic [WIDTH-1:0] input_PC;
  logic [WIDTH-1:0] input_imm;
  logic [1:0]       input_ALUSrcA;
  logic [1:0]       input_ALUSrcB;
  logic [2:0]       input_ALUOp;
  logic             input_PCSrc;
  logic             output_busy;
  logic             output_done;
  logic [WIDTH-1:0] output_ALUOut;
  logic             output_Zero;
  logic             output_negative;
  logic             output_carry;
  logic [WIDTH-1:0] output_nextPC;

  modport master (
    output input_start, input_A, input_B, input_PC, input_imm,
    output input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    input  output_busy, output_done, output_ALUOut, output_Zero,
    input  output_negative, output_carry, output_nextPC
  );

  modport slave (
    input  input_start, input_A, input_B, input_PC, input_imm,
    input  input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    output output_busy, output_done, output_ALUOut, output_Zero,
    output output_negative, output_carry, output_nextPC
  );
endinterface

// File: rtl/calc_datapath_mc.sv
// rtl/calc_datapath_mc.sv - multi-cycle ALU datapath with start/busy/done handshake
// Defining CALC_MUL_EN builds the iterative shift-add multiply for op 111.
module calc_datapath_mc #(
  parameter int WIDTH  = 16,
  parameter int PC_INC = 2
) (
  input  logic              clk,
  input  logic              reset,
  calc_datapath_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
`ifdef CALC_MUL_EN
  localparam logic [2:0] S_MUL  = 3'd4;
  localparam logic [2:0] OP_MUL = 3'b111;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRA = 3'b110;

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_reg_q, a_reg_d, b_reg_q, b_reg_d;
  logic [WIDTH-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [1:0]       srca_sel_q, srca_sel_d, srcb_sel_q, srcb_sel_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d, neg_q, neg_d, carry_q, carry_d;

  logic [WIDTH-1:0] src_a, src_b, alu_res;
  logic [WIDTH:0]   sum_ext;
  logic             alu_carry;
  logic [SHW-1:0]   shamt;

`ifdef CALC_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_sum;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // One multiplier bit per cycle; multiplicand and multiplier are the captured sources.
  always_comb begin
    mul_sum = acc_q;
    if (src_b[cnt_q]) mul_sum = acc_q + ({{WIDTH{1'b0}}, src_a} << cnt_q);
  end
`endif

  always_comb begin
    src_a = '0;
    src_b = '0;
    case (srca_sel_q)
      2'd0:    src_a = pc_q;
      2'd1:    src_a = WIDTH'(PC_INC);
      2'd2:    src_a = a_reg_q;
      default: src_a = '0;
    endcase
    case (srcb_sel_q)
      2'd0:    src_b = b_reg_q;
      2'd1:    src_b = WIDTH'(PC_INC);
      2'd2:    src_b = imm_q;
      default: src_b = '0;
    endcase
  end

  assign shamt = src_b[SHW-1:0];

  // Op 111 yields zero here; the multiply result comes only from the MUL iteration.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum_ext   = '0;
    case (op_q)
      OP_ADD: begin
        sum_ext   = {1'b0, src_a} + {1'b0, src_b};
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
      end
      OP_SUB: begin
        alu_res   = src_a - src_b;
        alu_carry = (src_a < src_b);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_reg_d    = a_reg_q;
    b_reg_d    = b_reg_q;
    imm_d      = imm_q;
    pc_d       = pc_q;
    srca_sel_d = srca_sel_q;
    srcb_sel_d = srcb_sel_q;
    op_d       = op_q;
    alu_out_d  = alu_out_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    carry_d    = carry_q;
`ifdef CALC_MUL_EN
    acc_d      = acc_q;
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.input_start) begin
          a_reg_d    = bus.input_A;
          b_reg_d    = bus.input_B;
          imm_d      = bus.input_imm;
          pc_d       = bus.input_PC;
          srca_sel_d = bus.input_ALUSrcA;
          srcb_sel_d = bus.input_ALUSrcB;
          op_d       = bus.input_ALUOp;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        alu_out_d = alu_res;
        zero_d    = (alu_res == '0);
        neg_d     = alu_res[WIDTH-1];
        carry_d   = alu_carry;
        state_d   = S_DONE;
`ifdef CALC_MUL_EN
        if (op_q == OP_MUL) begin
          alu_out_d = alu_out_q;
          zero_d    = zero_q;
          neg_d     = neg_q;
          carry_d   = carry_q;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = S_MUL;
        end
`endif
      end
`ifdef CALC_MUL_EN
      S_MUL: begin
        acc_d = mul_sum;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          alu_out_d = mul_sum[WIDTH-1:0];
          zero_d    = (mul_sum[WIDTH-1:0] == '0);
          neg_d     = mul_sum[WIDTH-1];
          carry_d   = |mul_sum[2*WIDTH-1:WIDTH];
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      a_reg_q    <= '0;
      b_reg_q    <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      srca_sel_q <= '0;
      srcb_sel_q <= '0;
      op_q       <= '0;
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
`ifdef CALC_MUL_EN
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_reg_q    <= a_reg_d;
      b_reg_q    <= b_reg_d;
      imm_q      <= imm_d;
      pc_q       <= pc_d;
      srca_sel_q <= srca_sel_d;
      srcb_sel_q <= srcb_sel_d;
      op_q       <= op_d;
      alu_out_q  <= alu_out_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      carry_q    <= carry_d;
`ifdef CALC_MUL_EN
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    bus.output_busy = (state_q == S_LOAD) || (state_q == S_EXEC);
`ifdef CALC_MUL_EN
    if (state_q == S_MUL) bus.output_busy = 1'b1;
`endif
  end

  assign bus.output_done     = (state_q == S_DONE);
  assign bus.output_ALUOut   = alu_out_q;
  assign bus.output_Zero     = zero_q;
  assign bus.output_negative = neg_q;
  assign bus.output_carry    = carry_q;
  assign bus.output_nextPC   = bus.input_PCSrc ? alu_out_q : alu_res;
endmodule

// File: tb/tb_calc_datapath_mc.sv
// tb/tb_calc_datapath_mc.sv - randomized self-checking bench for calc_datapath_mc
// Expected results come from an arithmetic model of the ALU rules; honours CALC_MUL_EN.
module tb_calc_datapath_mc;
  localparam int     W   = 16;
  localparam longint MOD = 64'd1 << W;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  calc_datapath_mc_if #(.WIDTH(W)) bus ();
  calc_datapath_mc #(.WIDTH(W), .PC_INC(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic longint pick_a(input int s, input longint a, input longint pc);
    case (s)
      0: return pc;
      1: return 2;
      2: return a;
      default: return 0;
    endcase
  endfunction

  function automatic longint pick_b(input int s, input longint b, input longint imm);
    case (s)
      0: return b;
      1: return 2;
      2: return imm;
      default: return 0;
    endcase
  endfunction

  task automatic model(input longint x, input longint y, input int op,
                       output longint res, output longint cy);
    cy = 0;
    case (op)
      0: begin res = (x + y) % MOD; cy = ((x + y) >= MOD); end
      1: begin res = (x - y + MOD) % MOD; cy = (x < y); end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: res = (x << (y % W)) % MOD;
      6: begin
        res = x;
        repeat (y % W) res = (res >> 1) | (res & (MOD / 2));
      end
      default: begin
`ifdef CALC_MUL_EN
        res = (x * y) % MOD;
        cy  = ((x * y) >= MOD);
`else
        res = 0;
`endif
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] pc, input logic [15:0] imm,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] op);
    longint res, cy;
    int     lat, exp_lat;
    bit     live_ok;
    model(pick_a(sa, a, pc), pick_b(sb, b, imm), op, res, cy);
    exp_lat = 3;
    live_ok = 1'b1;
`ifdef CALC_MUL_EN
    if (op == 3'b111) begin
      exp_lat = 3 + W;
      live_ok = 1'b0;
    end
`endif
    bus.input_A = a; bus.input_B = b; bus.input_PC = pc; bus.input_imm = imm;
    bus.input_ALUSrcA = sa; bus.input_ALUSrcB = sb; bus.input_ALUOp = op;
    bus.input_PCSrc = 1'b0;
    bus.input_start = 1'b1;
    @(posedge clk); #1;
    // Scramble everything after acceptance: the operation must use captured values.
    bus.input_start = 1'b0;
    bus.input_A = 16'($urandom); bus.input_B = 16'($urandom);
    bus.input_PC = 16'($urandom); bus.input_imm = 16'($urandom);
    bus.input_ALUSrcA = 2'($urandom); bus.input_ALUSrcB = 2'($urandom);
    bus.input_ALUOp = 3'($urandom);
    lat = 1;
    check({tag, "/busy_load"}, bus.output_busy, 1);
    while (!bus.output_done && lat < 40) begin
      if (lat == 2 && live_ok) check({tag, "/nextpc_live"}, bus.output_nextPC, res);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, lat, exp_lat);
    check({tag, "/aluout"}, bus.output_ALUOut, res);
    check({tag, "/zero"}, bus.output_Zero, (res == 0));
    check({tag, "/neg"}, bus.output_negative, (res >= MOD / 2));
    check({tag, "/carry"}, bus.output_carry, cy);
    check({tag, "/busy_done"}, bus.output_busy, 0);
    bus.input_PCSrc = 1'b1;
    #1;
    check({tag, "/nextpc_reg"}, bus.output_nextPC, res);
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, bus.output_done, 0);
    check({tag, "/hold"}, bus.output_ALUOut, res);
  endtask

  initial begin
    int dones, overlap;
    logic [15:0] ra, rb;
    reset = 1'b0;
    bus.input_start = 1'b0; bus.input_A = '0; bus.input_B = '0; bus.input_PC = '0;
    bus.input_imm = '0; bus.input_ALUSrcA = '0; bus.input_ALUSrcB = '0;
    bus.input_ALUOp = '0; bus.input_PCSrc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst/busy", bus.output_busy, 0);
    check("rst/done", bus.output_done, 0);
    check("rst/aluout", bus.output_ALUOut, 0);
    check("rst/zero", bus.output_Zero, 0);
    check("rst/neg", bus.output_negative, 0);
    check("rst/carry", bus.output_carry, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op("add", 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b000);
    check("add/const", bus.output_ALUOut, 16'h8000);
    run_op("sub_borrow", 16'h0003, 16'h0005, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b001);
    check("sub/const", bus.output_ALUOut, 16'hFFFE);
    run_op("sub_eq", 16'h1234, 16'h1234, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b001);
    check("sub_eq/zero_const", bus.output_Zero, 1);
    run_op("pc_inc", 16'h0000, 16'h0000, 16'h0040, 16'h0000, 2'd0, 2'd1, 3'b000);
    check("pc_inc/const", bus.output_ALUOut, 16'h0042);
    run_op("sra_neg", 16'h8010, 16'h0004, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b110);
    run_op("mul_a", 16'h0012, 16'h0034, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b111);
`ifdef CALC_MUL_EN
    check("mul_a/const", bus.output_ALUOut, 16'h03A8);
`else
    check("mul_a/const", bus.output_ALUOut, 16'h0000);
`endif
    run_op("mul_b", 16'h0100, 16'h0100, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b111);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      run_op($sformatf("rnd%0d", i), ra, rb, 16'($urandom), 16'($urandom),
             2'($urandom), 2'($urandom), 3'($urandom));
    end

    // Start held for 10 cycles: only starts seen in IDLE are taken.
    bus.input_A = 16'h1111; bus.input_B = 16'h2222;
    bus.input_ALUSrcA = 2'd2; bus.input_ALUSrcB = 2'd0; bus.input_ALUOp = 3'b000;
    bus.input_PCSrc = 1'b1;
    dones = 0;
    overlap = 0;
    for (int i = 0; i < 16; i++) begin
      bus.input_start = (i < 10);
      @(posedge clk); #1;
      if (bus.output_done) dones++;
      if (bus.output_done && bus.output_busy) overlap++;
    end
    bus.input_start = 1'b0;
    check("hs/dones", dones, 3);
    check("hs/overlap", overlap, 0);
    check("hs/aluout", bus.output_ALUOut, 16'h3333);

    bus.input_ALUOp = 3'b001;
    bus.input_start = 1'b1;
    @(posedge clk); #1;
    bus.input_start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst/busy", bus.output_busy, 0);
    check("midrst/done", bus.output_done, 0);
    check("midrst/aluout", bus.output_ALUOut, 0);
    check("midrst/zero", bus.output_Zero, 0);
    check("midrst/neg", bus.output_negative, 0);
    check("midrst/carry", bus.output_carry, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    dones = 0;
    overlap = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.output_done) dones++;
      if (bus.output_busy) overlap++;
    end
    check("midrst/no_done", dones, 0);
    check("midrst/idle", overlap, 0);
    run_op("post_rst", 16'h00F0, 16'h0F0F, 16'h0000, 16'h0000, 2'd2, 2'd0, 3'b011);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
